regfile_write_ctrl: RTL and testbench

Write-port controller for the register file. Shares the file's single write port (we, addr_rd, data_in) between two write-back requesters with a valid/ready handshake and round-robin arbitration. Also provides a clear sequencer that zeroes registers 1..DEPTH-1 on command. Sits between the execution/load write-back paths and the register file. The read ports (addr_rs1, addr_rs2) are not touched.

---
 rtl/regfile_ctrl_pkg.sv | 10 +
 rtl/rr_arbiter2.sv | 30 +++
 rtl/regfile_write_ctrl.sv | 120 ++++++++++++
 tb/tb_regfile_write_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and encodings for the register-file write-port controller.
package regfile_ctrl_pkg;

  typedef enum logic {ARB, CLEAR} wctrl_state_t;

  // last_grant encoding
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: the requester not granted last wins contention.
module rr_arbiter2
  import regfile_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic r_last_grant;

  // Grant: a lone requester always wins; on contention the one not granted last wins.
  always_comb begin
    gnt    = '0;
    gnt[0] = req[0] && (!req[1] || (r_last_grant == REQ1));
    gnt[1] = req[1] && (!req[0] || (r_last_grant == REQ0));
  end

  // Remember the winner of every completed transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= REQ1;
    end else if (advance) begin
      r_last_grant <= gnt[1] ? REQ1 : REQ0;
    end
  end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write-port controller: round-robin sharing of the single write
// port between two valid/ready requesters, plus a sweep that zeroes regs 1..DEPTH-1.
module regfile_write_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_addr,
  input  logic [W-1:0] req0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_addr,
  input  logic [W-1:0] req1_data,
  input  logic         clear_req,
  output logic         clear_busy,
  output logic         clear_done,
  output logic         we,
  output logic [N-1:0] addr_rd,
  output logic [W-1:0] data_in
);

  localparam logic [N-1:0] LAST_REG = '1;

  wctrl_state_t r_state, w_state_nxt;
  logic [N-1:0] r_cnt, w_cnt_nxt;
  logic         r_we, w_we_nxt;
  logic [N-1:0] r_addr, w_addr_nxt;
  logic [W-1:0] r_data, w_data_nxt;
  logic         r_done, w_done_nxt;

  logic         w_arb_en;
  logic [1:0]   w_req;
  logic [1:0]   w_gnt;
  logic         w_xfer;
  logic [N-1:0] w_xfer_addr;
  logic [W-1:0] w_xfer_data;

  // Requests reach the arbiter only while arbitrating and no clear is requested,
  // so a grant is exactly a transfer.
  assign w_arb_en    = (r_state == ARB) && !clear_req;
  assign w_req       = {req1_valid, req0_valid} & {2{w_arb_en}};
  assign w_xfer      = |w_gnt;
  assign w_xfer_addr = w_gnt[1] ? req1_addr : req0_addr;
  assign w_xfer_data = w_gnt[1] ? req1_data : req0_data;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (w_req),
    .advance (w_xfer),
    .gnt     (w_gnt)
  );

  // Next-state and next-output logic for arbitration and the clear sweep.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    case (r_state)
      ARB: begin
        if (clear_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = N'(1);
        end else if (w_xfer) begin
          // Writes to register 0 are accepted but never reach the file.
          w_we_nxt   = (w_xfer_addr != '0);
          w_addr_nxt = w_xfer_addr;
          w_data_nxt = w_xfer_data;
        end
      end
      CLEAR: begin
        w_we_nxt   = 1'b1;
        w_addr_nxt = r_cnt;
        w_data_nxt = '0;
        w_cnt_nxt  = r_cnt + N'(1);
        if (r_cnt == LAST_REG) begin
          w_state_nxt = ARB;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  // State, sweep counter and registered write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB;
      r_cnt   <= N'(1);
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign req0_ready = rst_n && w_gnt[0];
  assign req1_ready = rst_n && w_gnt[1];
  assign clear_busy = (r_state == CLEAR);
  assign clear_done = r_done;
  assign we         = r_we;
  assign addr_rd    = r_addr;
  assign data_in    = r_data;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl (N=4, W=16).
module tb_regfile_write_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [3:0]  req0_addr;
  logic [15:0] req0_data;
  logic        req1_valid, req1_ready;
  logic [3:0]  req1_addr;
  logic [15:0] req1_data;
  logic        clear_req, clear_busy, clear_done;
  logic        we;
  logic [3:0]  addr_rd;
  logic [15:0] data_in;

  int total = 0;
  int bad   = 0;

  regfile_write_ctrl #(.N(4), .W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .we         (we),
    .addr_rd    (addr_rd),
    .data_in    (data_in)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_addr = 4'd5; req0_data = 16'h1234;
    repeat (3) tick();
    @(negedge clk);
    total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", we); end
    total++; if (addr_rd !== 4'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", addr_rd); end
    total++; if (data_in !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0000", data_in); end
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0 got=%b exp=0", req0_ready); end
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready1 got=%b exp=0", req1_ready); end
    total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", clear_busy); end
    total++; if (clear_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", clear_done); end
    req0_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_contention();
    logic [3:0]  ea;
    logic [15:0] ed;
    req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 16'h1111;
    req1_valid = 1'b1; req1_addr = 4'd7; req1_data = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (req0_ready !== ((k % 2) == 0)) begin bad++; $display("FAIL cont_ready0[%0d] got=%b exp=%b", k, req0_ready, (k % 2) == 0); end
      total++; if (req1_ready !== ((k % 2) == 1)) begin bad++; $display("FAIL cont_ready1[%0d] got=%b exp=%b", k, req1_ready, (k % 2) == 1); end
      if (k > 0) begin
        ea = ((k - 1) % 2 == 0) ? 4'd3 : 4'd7;
        ed = ((k - 1) % 2 == 0) ? 16'h1111 : 16'h2222;
        total++; if (we !== 1'b1) begin bad++; $display("FAIL cont_we[%0d] got=%b exp=1", k, we); end
        total++; if (addr_rd !== ea) begin bad++; $display("FAIL cont_addr[%0d] got=%0d exp=%0d", k, addr_rd, ea); end
        total++; if (data_in !== ed) begin bad++; $display("FAIL cont_data[%0d] got=%h exp=%h", k, data_in, ed); end
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    total++; if (we !== 1'b1) begin bad++; $display("FAIL cont_last_we got=%b exp=1", we); end
    total++; if (addr_rd !== 4'd7) begin bad++; $display("FAIL cont_last_addr got=%0d exp=7", addr_rd); end
    total++; if (data_in !== 16'h2222) begin bad++; $display("FAIL cont_last_data got=%h exp=2222", data_in); end
    tick();
    @(negedge clk);
    total++; if (we !== 1'b0) begin bad++; $display("FAIL cont_idle_we got=%b exp=0", we); end
    tick();
  endtask

  task automatic test_single_write();
    req0_valid = 1'b1; req0_addr = 4'd5; req0_data = 16'hA5A5;
    @(negedge clk);
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL single_ready0 got=%b exp=1", req0_ready); end
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL single_ready1 got=%b exp=0", req1_ready); end
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    total++; if (we !== 1'b1) begin bad++; $display("FAIL single_we got=%b exp=1", we); end
    total++; if (addr_rd !== 4'd5) begin bad++; $display("FAIL single_addr got=%0d exp=5", addr_rd); end
    total++; if (data_in !== 16'hA5A5) begin bad++; $display("FAIL single_data got=%h exp=a5a5", data_in); end
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL single_ready_drop got=%b exp=0", req0_ready); end
    tick();
    @(negedge clk);
    total++; if (we !== 1'b0) begin bad++; $display("FAIL single_idle_we got=%b exp=0", we); end
    total++; if (addr_rd !== 4'd5) begin bad++; $display("FAIL single_hold_addr got=%0d exp=5", addr_rd); end
    total++; if (data_in !== 16'hA5A5) begin bad++; $display("FAIL single_hold_data got=%h exp=a5a5", data_in); end
    tick();
  endtask

  task automatic test_reg0();
    req1_valid = 1'b1; req1_addr = 4'd0; req1_data = 16'hFFFF;
    @(negedge clk);
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL reg0_ready1 got=%b exp=1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    total++; if (we !== 1'b0) begin bad++; $display("FAIL reg0_we got=%b exp=0", we); end
    tick();
  endtask

  task automatic test_clear();
    clear_req = 1'b1;
    req0_valid = 1'b1; req0_addr = 4'd9; req0_data = 16'h9999;
    @(negedge clk);
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL clr_ready0_t got=%b exp=0", req0_ready); end
    total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL clr_busy_t got=%b exp=0", clear_busy); end
    tick();
    clear_req = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      total++; if (req0_ready !== (k == 16)) begin bad++; $display("FAIL clr_ready0[t+%0d] got=%b exp=%b", k, req0_ready, k == 16); end
      total++; if (clear_busy !== (k <= 15)) begin bad++; $display("FAIL clr_busy[t+%0d] got=%b exp=%b", k, clear_busy, k <= 15); end
      total++; if (clear_done !== (k == 16)) begin bad++; $display("FAIL clr_done[t+%0d] got=%b exp=%b", k, clear_done, k == 16); end
      total++; if (we !== (k >= 2)) begin bad++; $display("FAIL clr_we[t+%0d] got=%b exp=%b", k, we, k >= 2); end
      if (k >= 2) begin
        total++; if (addr_rd !== 4'(k - 1)) begin bad++; $display("FAIL clr_addr[t+%0d] got=%0d exp=%0d", k, addr_rd, k - 1); end
        total++; if (data_in !== 16'h0) begin bad++; $display("FAIL clr_data[t+%0d] got=%h exp=0000", k, data_in); end
      end
      tick();
    end
    req0_valid = 1'b0;
    @(negedge clk);
    total++; if (we !== 1'b1) begin bad++; $display("FAIL clr_after_we got=%b exp=1", we); end
    total++; if (addr_rd !== 4'd9) begin bad++; $display("FAIL clr_after_addr got=%0d exp=9", addr_rd); end
    total++; if (data_in !== 16'h9999) begin bad++; $display("FAIL clr_after_data got=%h exp=9999", data_in); end
    total++; if (clear_done !== 1'b0) begin bad++; $display("FAIL clr_after_done got=%b exp=0", clear_done); end
    tick();
  endtask

  task automatic test_reset_mid_clear();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (4) tick();
    // now in cycle t+5 of the sweep
    rst_n = 1'b0;
    #1;
    total++; if (we !== 1'b0) begin bad++; $display("FAIL rmc_we got=%b exp=0", we); end
    total++; if (addr_rd !== 4'd0) begin bad++; $display("FAIL rmc_addr got=%0d exp=0", addr_rd); end
    total++; if (data_in !== 16'h0) begin bad++; $display("FAIL rmc_data got=%h exp=0000", data_in); end
    total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL rmc_busy got=%b exp=0", clear_busy); end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      total++; if (we !== 1'b0 || clear_done !== 1'b0 || clear_busy !== 1'b0) begin
        bad++; $display("FAIL rmc_quiet[%0d] got we=%b done=%b busy=%b exp=0/0/0", k, we, clear_done, clear_busy);
      end
    end
    tick();
    req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 16'h0202;
    @(negedge clk);
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL rmc_ready1 got=%b exp=1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    total++; if (we !== 1'b1 || addr_rd !== 4'd2 || data_in !== 16'h0202) begin
      bad++; $display("FAIL rmc_write got we=%b addr=%0d data=%h exp=1/2/0202", we, addr_rd, data_in);
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    clear_req  = 1'b0;
    test_reset();
    test_contention();
    test_single_write();
    test_reg0();
    test_clear();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
